// File: rtl/mm_tile_scheduler.sv
// Tile scheduler for the matmul engine: walks (m,n,k) tiles, ping-pongs two banksets
// between the loader and the PE array, and hands finished output tiles to the drainer.
module mm_tile_scheduler #(
  parameter int T    = 16,
  parameter int DW   = 16,
  parameter int SETS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_M,
  input  logic [DW-1:0] cfg_N,
  input  logic [DW-1:0] cfg_K,
  input  logic [DW-1:0] cfg_Tm,
  input  logic [DW-1:0] cfg_Tn,
  input  logic [DW-1:0] cfg_Tk,
  output logic          busy,
  output logic          done,
  output logic          err_cfg,
  output logic          aborted,
  output logic          ld_valid,
  input  logic          ld_ready,
  output logic          ld_set,
  output logic [DW-1:0] ld_m0,
  output logic [DW-1:0] ld_n0,
  output logic [DW-1:0] ld_k0,
  output logic [DW-1:0] ld_rows,
  output logic [DW-1:0] ld_cols,
  output logic [DW-1:0] ld_depth,
  input  logic          ld_done,
  input  logic          ld_done_set,
  output logic          cp_valid,
  input  logic          cp_ready,
  output logic          cp_set,
  output logic          cp_first_k,
  output logic          cp_last_k,
  input  logic          cp_done,
  input  logic          cp_done_set,
  output logic          dr_valid,
  input  logic          dr_ready,
  output logic [DW-1:0] dr_m0,
  output logic [DW-1:0] dr_n0,
  output logic [DW-1:0] dr_rows,
  output logic [DW-1:0] dr_cols,
  input  logic          dr_done,
  output logic [DW-1:0] tiles_done
);
  typedef enum logic [2:0] {IDLE, CHECK, RUN, ABORTING, FIN} state_t;
  typedef enum logic [1:0] {S_FREE, S_LOADING, S_FULL, S_COMPUTING} set_st_t;
  typedef struct packed {
    logic          first_k;
    logic          last_k;
    logic [DW-1:0] m0;
    logic [DW-1:0] n0;
    logic [DW-1:0] rows;
    logic [DW-1:0] cols;
  } set_meta_t;

  localparam logic [DW-1:0] TMAX = DW'(T);

  state_t        state, state_nxt;
  set_st_t       set_st [SETS];
  set_meta_t     meta   [SETS];
  logic [DW-1:0] c_m, c_n, c_k, c_tm, c_tn, c_tk;
  logic [DW-1:0] it_m, it_n, it_k;
  logic          all_issued, ld_ptr, cp_ptr, drain_pending, ld_first, ld_last;

  logic          cfg_bad, all_free, quiet, run_fin, abort_fin, ld_elig, cp_elig, cp_done_ok;
  logic [DW:0]   m_nxt, n_nxt, k_nxt;
  logic          m_end, n_end, k_end;
  logic [DW-1:0] rem_m, rem_n, rem_k, rows_c, cols_c, depth_c;

  assign cfg_bad = (c_m == '0) | (c_n == '0) | (c_k == '0) |
                   (c_tm == '0) | (c_tn == '0) | (c_tk == '0) |
                   (c_tm > TMAX) | (c_tn > TMAX) | (c_tk > TMAX);

  // iterator is kept in range by construction, so the remaining extent never underflows
  assign m_nxt   = {1'b0, it_m} + {1'b0, c_tm};
  assign n_nxt   = {1'b0, it_n} + {1'b0, c_tn};
  assign k_nxt   = {1'b0, it_k} + {1'b0, c_tk};
  assign m_end   = m_nxt >= {1'b0, c_m};
  assign n_end   = n_nxt >= {1'b0, c_n};
  assign k_end   = k_nxt >= {1'b0, c_k};
  assign rem_m   = c_m - it_m;
  assign rem_n   = c_n - it_n;
  assign rem_k   = c_k - it_k;
  assign rows_c  = (c_tm < rem_m) ? c_tm : rem_m;
  assign cols_c  = (c_tn < rem_n) ? c_tn : rem_n;
  assign depth_c = (c_tk < rem_k) ? c_tk : rem_k;

  always_comb begin
    all_free = 1'b1;
    for (int s = 0; s < SETS; s++)
      if (set_st[s] != S_FREE) all_free = 1'b0;
  end

  assign quiet      = all_free & ~drain_pending & ~ld_valid & ~cp_valid & ~dr_valid;
  assign run_fin    = all_issued & quiet;
  assign abort_fin  = quiet;
  assign ld_elig    = (state == RUN) & ~abort & ~all_issued & (set_st[ld_ptr] == S_FREE);
  // a fresh first_k compute would clear accumulators the drainer still has to read
  assign cp_elig    = (state == RUN) & ~abort & (set_st[cp_ptr] == S_FULL) &
                      (~meta[cp_ptr].first_k | ~drain_pending);
  assign cp_done_ok = cp_done & (set_st[cp_done_set] == S_COMPUTING);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = CHECK;
      CHECK:    state_nxt = cfg_bad ? FIN : RUN;
      RUN:      if (abort) state_nxt = ABORTING;
                else if (run_fin) state_nxt = FIN;
      ABORTING: if (abort_fin) state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        set_st[s] <= S_FREE;
        meta[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < SETS; s++) begin
        unique case (set_st[s])
          S_FREE:
            if (ld_valid && ld_ready && ld_set == 1'(s)) begin
              set_st[s] <= S_LOADING;
              meta[s]   <= {ld_first, ld_last, ld_m0, ld_n0, ld_rows, ld_cols};
            end
          S_LOADING:
            if (ld_done && ld_done_set == 1'(s)) set_st[s] <= S_FULL;
          S_FULL:
            if (cp_valid && cp_ready && cp_set == 1'(s)) set_st[s] <= S_COMPUTING;
            else if (state == ABORTING && !(cp_valid && cp_set == 1'(s))) set_st[s] <= S_FREE;
          S_COMPUTING:
            if (cp_done && cp_done_set == 1'(s)) set_st[s] <= S_FREE;
          default: set_st[s] <= S_FREE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {c_m, c_n, c_k, c_tm, c_tn, c_tk} <= '0;
      {it_m, it_n, it_k} <= '0;
      {all_issued, ld_ptr, cp_ptr, drain_pending, ld_first, ld_last} <= '0;
      {busy, done, err_cfg, aborted} <= '0;
      {ld_valid, ld_set, ld_m0, ld_n0, ld_k0, ld_rows, ld_cols, ld_depth} <= '0;
      {cp_valid, cp_set, cp_first_k, cp_last_k} <= '0;
      {dr_valid, dr_m0, dr_n0, dr_rows, dr_cols} <= '0;
      tiles_done <= '0;
    end else begin
      done <= (state == FIN);
      if (state == IDLE && start) begin
        {c_m, c_n, c_k, c_tm, c_tn, c_tk} <= {cfg_M, cfg_N, cfg_K, cfg_Tm, cfg_Tn, cfg_Tk};
        {it_m, it_n, it_k} <= '0;
        {all_issued, ld_ptr, cp_ptr, drain_pending} <= '0;
        {err_cfg, aborted} <= '0;
        tiles_done <= '0;
        busy       <= 1'b1;
      end else if (state == FIN) begin
        busy <= 1'b0;
      end
      if (state == CHECK && cfg_bad) err_cfg <= 1'b1;
      if (state == RUN && abort)     aborted <= 1'b1;

      if (ld_valid) begin
        if (ld_ready) begin
          ld_valid <= 1'b0;
          ld_ptr   <= ~ld_ptr;
          if (k_end) begin
            it_k <= '0;
            if (n_end) begin
              it_n <= '0;
              if (m_end) all_issued <= 1'b1;
              else       it_m <= m_nxt[DW-1:0];
            end else it_n <= n_nxt[DW-1:0];
          end else it_k <= k_nxt[DW-1:0];
        end
      end else if (ld_elig) begin
        ld_valid <= 1'b1;
        ld_set   <= ld_ptr;
        {ld_m0, ld_n0, ld_k0} <= {it_m, it_n, it_k};
        {ld_rows, ld_cols, ld_depth} <= {rows_c, cols_c, depth_c};
        ld_first <= (it_k == '0);
        ld_last  <= k_end;
      end

      if (cp_valid) begin
        if (cp_ready) begin
          cp_valid <= 1'b0;
          cp_ptr   <= ~cp_ptr;
        end
      end else if (cp_elig) begin
        cp_valid   <= 1'b1;
        cp_set     <= cp_ptr;
        cp_first_k <= meta[cp_ptr].first_k;
        cp_last_k  <= meta[cp_ptr].last_k;
      end

      if (dr_valid && dr_ready) dr_valid <= 1'b0;
      if (cp_done_ok && meta[cp_done_set].last_k && state == RUN) begin
        drain_pending <= 1'b1;
        dr_valid      <= 1'b1;
        {dr_m0, dr_n0} <= {meta[cp_done_set].m0, meta[cp_done_set].n0};
        {dr_rows, dr_cols} <= {meta[cp_done_set].rows, meta[cp_done_set].cols};
      end else if (dr_done && drain_pending) begin
        drain_pending <= 1'b0;
        tiles_done    <= tiles_done + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mm_tile_scheduler.sv
// Scoreboard bench: expected load/compute/drain commands are queued per job and
// compared as the loader, PE and drainer responders accept them.
module tb_mm_tile_scheduler;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, abort, busy, done, err_cfg, aborted;
  logic [DW-1:0] cfg_M, cfg_N, cfg_K, cfg_Tm, cfg_Tn, cfg_Tk, tiles_done;
  logic          ld_valid, ld_ready, ld_set, ld_done, ld_done_set;
  logic [DW-1:0] ld_m0, ld_n0, ld_k0, ld_rows, ld_cols, ld_depth;
  logic          cp_valid, cp_ready, cp_set, cp_first_k, cp_last_k, cp_done, cp_done_set;
  logic          dr_valid, dr_ready, dr_done;
  logic [DW-1:0] dr_m0, dr_n0, dr_rows, dr_cols;

  mm_tile_scheduler #(.T(16), .DW(DW), .SETS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_M(cfg_M), .cfg_N(cfg_N), .cfg_K(cfg_K),
    .cfg_Tm(cfg_Tm), .cfg_Tn(cfg_Tn), .cfg_Tk(cfg_Tk),
    .busy(busy), .done(done), .err_cfg(err_cfg), .aborted(aborted),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_set(ld_set),
    .ld_m0(ld_m0), .ld_n0(ld_n0), .ld_k0(ld_k0),
    .ld_rows(ld_rows), .ld_cols(ld_cols), .ld_depth(ld_depth),
    .ld_done(ld_done), .ld_done_set(ld_done_set),
    .cp_valid(cp_valid), .cp_ready(cp_ready), .cp_set(cp_set),
    .cp_first_k(cp_first_k), .cp_last_k(cp_last_k),
    .cp_done(cp_done), .cp_done_set(cp_done_set),
    .dr_valid(dr_valid), .dr_ready(dr_ready),
    .dr_m0(dr_m0), .dr_n0(dr_n0), .dr_rows(dr_rows), .dr_cols(dr_cols),
    .dr_done(dr_done), .tiles_done(tiles_done)
  );

  logic [127:0] ld_pay, cp_pay, dr_pay;
  assign ld_pay = {30'b0, ld_valid, ld_set, ld_m0, ld_n0, ld_k0, ld_rows, ld_cols, ld_depth};
  assign cp_pay = {124'b0, cp_valid, cp_set, cp_first_k, cp_last_k};
  assign dr_pay = {63'b0, dr_valid, dr_m0, dr_n0, dr_rows, dr_cols};

  int           n_chk = 0, n_fail = 0, cp_hs_cnt = 0, cp_fix = 0;
  bit           rnd = 1'b0;
  logic [1:0]   occ;
  logic [127:0] ld_q[$], cp_q[$], dr_q[$];
  time          ld_t[$], cpd_t[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int dly(input int fixed);
    return rnd ? int'($urandom_range(20, 0)) : fixed;
  endfunction

  initial begin : loader
    logic [127:0] snap;
    int d;
    ld_ready = 1'b0; ld_done = 1'b0; ld_done_set = 1'b0;
    forever begin
      @(negedge clk);
      if (ld_valid === 1'b1) begin
        snap = ld_pay;
        d = dly(0);
        repeat (d) begin @(negedge clk); chk("ld_hold", ld_pay, snap); end
        ld_ready = 1'b1;
        if (ld_q.size() == 0) chk("ld_extra", 128'(1), 128'(0));
        else chk("ld_cmd", snap, ld_q.pop_front());
        chk("ld_alloc", 128'(occ[snap[96]]), 128'(0));
        occ[snap[96]] = 1'b1;
        ld_t.push_back($time);
        @(negedge clk);
        ld_ready = 1'b0;
        d = dly(0);
        repeat (d) @(negedge clk);
        ld_done = 1'b1; ld_done_set = snap[96];
        @(negedge clk);
        ld_done = 1'b0;
      end
    end
  end

  initial begin : computer
    logic [127:0] snap;
    int d;
    cp_ready = 1'b0; cp_done = 1'b0; cp_done_set = 1'b0;
    forever begin
      @(negedge clk);
      if (cp_valid === 1'b1) begin
        snap = cp_pay;
        d = dly(0);
        repeat (d) begin @(negedge clk); chk("cp_hold", cp_pay, snap); end
        cp_ready = 1'b1;
        if (cp_q.size() == 0) chk("cp_extra", 128'(1), 128'(0));
        else chk("cp_cmd", snap, cp_q.pop_front());
        @(negedge clk);
        cp_ready = 1'b0;
        cp_hs_cnt++;
        d = dly(cp_fix);
        repeat (d) @(negedge clk);
        cp_done = 1'b1; cp_done_set = snap[2];
        occ[snap[2]] = 1'b0;
        cpd_t.push_back($time);
        @(negedge clk);
        cp_done = 1'b0;
      end
    end
  end

  initial begin : drainer
    logic [127:0] snap;
    int d;
    dr_ready = 1'b0; dr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (dr_valid === 1'b1) begin
        snap = dr_pay;
        d = dly(0);
        repeat (d) begin @(negedge clk); chk("dr_hold", dr_pay, snap); end
        dr_ready = 1'b1;
        if (dr_q.size() == 0) chk("dr_extra", 128'(1), 128'(0));
        else chk("dr_cmd", snap, dr_q.pop_front());
        @(negedge clk);
        dr_ready = 1'b0;
        d = dly(0);
        repeat (d) @(negedge clk);
        dr_done = 1'b1;
        @(negedge clk);
        dr_done = 1'b0;
      end
    end
  end

  // Reference tile walk: k innermost, then n, then m; sets alternate per load.
  task automatic gen(input int M, N, K, Tm, Tn, Tk, output int tiles);
    int idx, r, c, d;
    idx = 0; tiles = 0;
    for (int m = 0; m < M; m += Tm)
      for (int n = 0; n < N; n += Tn) begin
        tiles++;
        r = (M - m < Tm) ? M - m : Tm;
        c = (N - n < Tn) ? N - n : Tn;
        for (int k = 0; k < K; k += Tk) begin
          d = (K - k < Tk) ? K - k : Tk;
          ld_q.push_back({30'b0, 1'b1, 1'(idx % 2), 16'(m), 16'(n), 16'(k), 16'(r), 16'(c), 16'(d)});
          cp_q.push_back({124'b0, 1'b1, 1'(idx % 2), (k == 0), (k + Tk >= K)});
          if (k + Tk >= K) dr_q.push_back({63'b0, 1'b1, 16'(m), 16'(n), 16'(r), 16'(c)});
          idx++;
        end
      end
  endtask

  task automatic run_job(input string nm, input int M, N, K, Tm, Tn, Tk, input bit do_abort,
                         output int lat_done, output int lat_ld);
    int tiles, cyc, base, rises;
    bit ab_set, good;
    logic [2:0] prev, cur;
    ld_q.delete(); cp_q.delete(); dr_q.delete(); ld_t.delete(); cpd_t.delete();
    occ = 2'b00; tiles = 0; rises = 0; ab_set = 1'b0; prev = 3'b000;
    good = (M > 0) && (N > 0) && (K > 0) && (Tm > 0) && (Tn > 0) && (Tk > 0) &&
           (Tm <= 16) && (Tn <= 16) && (Tk <= 16);
    if (good) gen(M, N, K, Tm, Tn, Tk, tiles);
    cfg_M = 16'(M); cfg_N = 16'(N); cfg_K = 16'(K);
    cfg_Tm = 16'(Tm); cfg_Tn = 16'(Tn); cfg_Tk = 16'(Tk);
    base = cp_hs_cnt;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat_ld = 0;
    for (cyc = 1; cyc <= 20000; cyc++) begin
      @(posedge clk);
      #1;
      if (ld_valid && lat_ld == 0) lat_ld = cyc;
      cur = {ld_valid, cp_valid, dr_valid};
      if (ab_set) begin
        rises += $countones(cur & ~prev);
        abort = 1'b0;
      end
      prev = cur;
      if (do_abort && !ab_set && cp_hs_cnt > base) begin
        abort = 1'b1; ab_set = 1'b1;
      end
      if (done) break;
    end
    lat_done = cyc;
    chk({nm, "_done_seen"}, 128'(cyc <= 20000), 128'(1));
    chk({nm, "_busy_at_done"}, 128'(busy), 128'(0));
    if (do_abort) begin
      chk({nm, "_no_new_valid"}, 128'(rises), 128'(0));
      chk({nm, "_aborted"}, 128'(aborted), 128'(1));
      chk({nm, "_done_after_cpd"}, 128'(cpd_t.size() > 0 && cpd_t[$] < $time), 128'(1));
      chk({nm, "_tiles"}, 128'(tiles_done), 128'(0));
    end else begin
      chk({nm, "_ld_left"}, 128'(ld_q.size()), 128'(0));
      chk({nm, "_cp_left"}, 128'(cp_q.size()), 128'(0));
      chk({nm, "_dr_left"}, 128'(dr_q.size()), 128'(0));
      chk({nm, "_tiles"}, 128'(tiles_done), 128'(tiles));
      chk({nm, "_aborted"}, 128'(aborted), 128'(0));
    end
    @(posedge clk);
    #1 chk({nm, "_done_pulse"}, 128'(done), 128'(0));
    repeat (5) @(posedge clk);
  endtask

  initial begin : main
    int ld_lat, dn_lat;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_M = '0; cfg_N = '0; cfg_K = '0; cfg_Tm = '0; cfg_Tn = '0; cfg_Tk = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valids", 128'({ld_valid, cp_valid, dr_valid}), 128'(0));
    chk("rst_status", 128'({busy, done, err_cfg, aborted}), 128'(0));
    chk("rst_tiles", 128'(tiles_done), 128'(0));
    chk("rst_payload", ld_pay | dr_pay, 128'(0));
    rst = 1'b1;
    repeat (2) @(posedge clk);

    run_job("single", 16, 16, 16, 16, 16, 16, 1'b0, dn_lat, ld_lat);
    chk("single_ld_latency", 128'(ld_lat), 128'(2));

    run_job("kblk", 16, 16, 64, 16, 16, 16, 1'b0, dn_lat, ld_lat);
    chk("kblk_overlap", 128'(ld_t.size() >= 2 && cpd_t.size() >= 1 && ld_t[1] < cpd_t[0]), 128'(1));

    run_job("mclip", 20, 16, 16, 16, 16, 16, 1'b0, dn_lat, ld_lat);

    run_job("bad_tk0", 16, 16, 16, 16, 16, 0, 1'b0, dn_lat, ld_lat);
    chk("bad_tk0_err", 128'(err_cfg), 128'(1));
    chk("bad_tk0_no_ld", 128'(ld_lat), 128'(0));
    chk("bad_tk0_latency", 128'(dn_lat), 128'(2));

    run_job("bad_tm17", 16, 16, 16, 17, 16, 16, 1'b0, dn_lat, ld_lat);
    chk("bad_tm17_err", 128'(err_cfg), 128'(1));
    chk("bad_tm17_no_ld", 128'(ld_lat), 128'(0));
    chk("bad_tm17_latency", 128'(dn_lat), 128'(2));

    rnd = 1'b1;
    run_job("random", 40, 20, 50, 16, 8, 12, 1'b0, dn_lat, ld_lat);
    chk("random_err_clear", 128'(err_cfg), 128'(0));

    rnd = 1'b0; cp_fix = 15;
    run_job("abort", 16, 16, 64, 16, 16, 16, 1'b1, dn_lat, ld_lat);

    // async reset mid-job: everything must clear before the next clock edge
    cp_fix = 0;
    ld_q.delete(); cp_q.delete(); dr_q.delete();
    cfg_M = 16'd16; cfg_N = 16'd16; cfg_K = 16'd64;
    cfg_Tm = 16'd16; cfg_Tn = 16'd16; cfg_Tk = 16'd16;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("midjob_busy", 128'(busy), 128'(1));
    rst = 1'b0;
    #1;
    chk("async_rst_valids", 128'({ld_valid, cp_valid, dr_valid}), 128'(0));
    chk("async_rst_status", 128'({busy, done, err_cfg, aborted}), 128'(0));
    chk("async_rst_payload", ld_pay, 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
